// File: rtl/uart_pkg.sv
// Shared definitions for the UART serialiser and its bit timer.
// Frame geometry helpers are functions so each instance derives its own widths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int MAX_W         = 16;
    localparam int MAX_STOP_BITS = 2;

    // Total bits on the line per frame: start + data + stop.
    function automatic int frame_bits(input int w, input int stop_bits);
        return 1 + w + stop_bits;
    endfunction

    // The bit counter holds W-1 during data and STOP_BITS-1 during stop.
    function automatic int cnt_width(input int w, input int stop_bits);
        int m;
        m = (w > stop_bits) ? w : stop_bits;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: load sets the period, tick marks the last cycle of a bit.
// Latency: tick is combinational from the count, so a bit lasts reload+1 cycles.
// Backpressure: none; the owner reloads on the tick cycle so the count never wraps.
module uart_bit_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] reload,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= reload;
        end else if (count != '0) begin
            count <= count - DIV_W'(1);
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/uart_tx_serialiser.sv
// UART transmit framer driving a pin register through d and a bit-edge load strobe e.
// Latency: accept on edge T puts the start bit on pin_d with pin_e=1 at T+1.
// Backpressure: tx_ready only while idle or in the final cycle of the last stop bit.
module uart_tx_serialiser
    import uart_pkg::*;
#(
    parameter int W         = 8,
    parameter int DIV_W     = 16,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] clkdiv,
    input  logic [W-1:0]     tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             busy,
    output logic             pin_d,
    output logic             pin_e
);

    localparam int CNT_W = cnt_width(W, STOP_BITS);

    state_t           state;
    logic [W-1:0]     shreg;
    logic [W-1:0]     shreg_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic             accept;
    logic             last_bit;
    logic             timer_load;
    logic [DIV_W-1:0] timer_reload;

    assign shreg_nxt = shreg >> 1;
    assign last_bit  = (bit_cnt == '0);
    assign tx_ready  = !rst && ((state == IDLE) || (state == STOP && tick && last_bit));
    assign accept    = tx_valid && tx_ready;

    // A fresh frame times from the live clkdiv; later bits reuse the latched copy.
    assign timer_load   = accept || (tick && state != IDLE);
    assign timer_reload = accept ? clkdiv : div_q;

    uart_bit_timer #(
        .DIV_W (DIV_W)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .reload (timer_reload),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div_q   <= '0;
            pin_d   <= 1'b1;
            pin_e   <= 1'b1;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pin_d <= 1'b1;
                    pin_e <= 1'b1;
                    busy  <= 1'b0;
                    if (accept) begin
                        state <= START;
                        shreg <= tx_data;
                        div_q <= clkdiv;
                        pin_d <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        bit_cnt <= CNT_W'(W - 1);
                        pin_d   <= shreg[0];
                        pin_e   <= 1'b1;
                    end else begin
                        pin_e <= 1'b0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg <= shreg_nxt;
                        pin_e <= 1'b1;
                        if (last_bit) begin
                            state   <= STOP;
                            bit_cnt <= CNT_W'(STOP_BITS - 1);
                            pin_d   <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt - CNT_W'(1);
                            pin_d   <= shreg_nxt[0];
                        end
                    end else begin
                        pin_e <= 1'b0;
                    end
                end
                STOP: begin
                    if (tick) begin
                        pin_e <= 1'b1;
                        pin_d <= 1'b1;
                        if (!last_bit) begin
                            bit_cnt <= bit_cnt - CNT_W'(1);
                        end else if (accept) begin
                            // Back-to-back frame: start bit follows the stop bit directly.
                            state <= START;
                            shreg <= tx_data;
                            div_q <= clkdiv;
                            pin_d <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        pin_e <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serialiser.sv
// Randomised bench for two serialiser builds (8N1 and 7-bit/2-stop) against a per-cycle frame model.
module tb_uart_tx_serialiser;

    typedef struct packed {
        logic d;
        logic e;
    } cyc_t;

    logic        clk;
    logic        rst;
    logic [15:0] clkdiv;
    logic [7:0]  tx_data;
    logic        tx_valid;

    logic tx_ready8, busy8, pin_d8, pin_e8;
    logic tx_ready7, busy7, pin_d7, pin_e7;
    logic pin_q8, pin_q7;

    cyc_t q8[$];
    cyc_t q7[$];
    logic line8, line7;
    int   n_chk, n_pass;

    uart_tx_serialiser #(.W(8), .DIV_W(16), .STOP_BITS(1)) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .clkdiv   (clkdiv),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready8),
        .busy     (busy8),
        .pin_d    (pin_d8),
        .pin_e    (pin_e8)
    );

    uart_tx_serialiser #(.W(7), .DIV_W(16), .STOP_BITS(2)) u_dut7 (
        .clk      (clk),
        .rst      (rst),
        .clkdiv   (clkdiv),
        .tx_data  (tx_data[6:0]),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready7),
        .busy     (busy7),
        .pin_d    (pin_d7),
        .pin_e    (pin_e7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream pin registers, cleared with the block so the line reads idle-high.
    always_ff @(posedge clk) begin
        pin_q8 <= rst ? 1'b1 : (pin_e8 ? pin_d8 : pin_q8);
        pin_q7 <= rst ? 1'b1 : (pin_e7 ? pin_d7 : pin_q7);
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expand one word into the expected per-cycle (d, e) stream of its frame.
    task automatic push_frame(input int k, input logic [15:0] data, input int w,
                              input int stop, input int div);
        cyc_t c;
        logic bitv;
        for (int b = 0; b < 1 + w + stop; b++) begin
            if (b == 0)      bitv = 1'b0;
            else if (b <= w) bitv = data[b-1];
            else             bitv = 1'b1;
            for (int j = 0; j <= div; j++) begin
                c.d = bitv;
                c.e = (j == 0);
                if (k == 0) q8.push_back(c);
                else        q7.push_back(c);
            end
        end
    endtask

    task automatic check_dut(input int k, input logic busy_o, input logic e_o, input logic d_o,
                             input logic rdy_o, input logic pin_o);
        cyc_t  c;
        logic  b;
        logic  empty;
        string p;
        p = (k == 0) ? "w8" : "w7";
        c.d = 1'b1;
        c.e = 1'b1;
        b   = 1'b0;
        if (k == 0) begin
            if (q8.size() > 0) begin c = q8.pop_front(); b = 1'b1; end
            empty = (q8.size() == 0);
        end else begin
            if (q7.size() > 0) begin c = q7.pop_front(); b = 1'b1; end
            empty = (q7.size() == 0);
        end
        chk_eq({p, "_busy"}, 32'(busy_o), 32'(b));
        chk_eq({p, "_pin_e"}, 32'(e_o), 32'(c.e));
        if (c.e) chk_eq({p, "_pin_d"}, 32'(d_o), 32'(c.d));
        chk_eq({p, "_tx_ready"}, 32'(rdy_o), 32'(!rst && empty));
        if (k == 0) begin
            chk_eq({p, "_line"}, 32'(pin_o), 32'(line8));
            if (c.e) line8 = c.d;
        end else begin
            chk_eq({p, "_line"}, 32'(pin_o), 32'(line7));
            if (c.e) line7 = c.d;
        end
    endtask

    // One cycle: check outputs at the falling edge, then drive inputs for the next rising edge.
    task automatic step(input logic v, input logic [7:0] d, input logic [15:0] dv,
                        input logic r, output logic acc);
        @(negedge clk);
        check_dut(0, busy8, pin_e8, pin_d8, tx_ready8, pin_q8);
        check_dut(1, busy7, pin_e7, pin_d7, tx_ready7, pin_q7);
        rst      = r;
        tx_valid = v;
        tx_data  = d;
        clkdiv   = dv;
        if (r) begin
            q8.delete();
            q7.delete();
            line8 = 1'b1;
            line7 = 1'b1;
        end
        acc = v && !r && (q8.size() == 0);
        if (acc) push_frame(0, {8'h00, d}, 8, 1, int'(dv));
        if (v && !r && (q7.size() == 0)) push_frame(1, {9'h000, d[6:0]}, 7, 2, int'(dv));
    endtask

    task automatic idle(input int n, input logic [15:0] dv);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), dv, 1'b0, acc);
    endtask

    initial begin
        logic acc;
        int   gap;
        n_chk    = 0;
        n_pass   = 0;
        line8    = 1'b1;
        line7    = 1'b1;
        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        clkdiv   = 16'd3;

        // Reset held with tx_valid high: nothing accepted.
        for (int i = 0; i < 3; i++) step(1'b1, 8'h3C, 16'd3, 1'b1, acc);
        step(1'b0, 8'h00, 16'd3, 1'b0, acc);
        idle(2, 16'd3);

        // Single 8N1 frame, period 4.
        step(1'b1, 8'hA5, 16'd3, 1'b0, acc);
        chk_eq("a5_accept", 32'(acc), 32'd1);
        idle(45, 16'd3);

        // One cycle per bit, two frames back to back.
        step(1'b1, 8'h00, 16'd0, 1'b0, acc);
        chk_eq("b2b_first_accept", 32'(acc), 32'd1);
        gap = 0;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            step(1'b1, 8'hFF, 16'd0, 1'b0, acc);
            gap++;
        end
        chk_eq("b2b_accept", 32'(acc), 32'd1);
        chk_eq("b2b_gap", 32'(gap), 32'd10);
        idle(15, 16'd0);

        // clkdiv and tx_data wander mid-frame; the next frame picks up period 8.
        step(1'b1, 8'h3C, 16'd3, 1'b0, acc);
        for (int i = 0; i < 40; i++) step(1'b0, 8'($urandom), 16'd7, 1'b0, acc);
        step(1'b1, 8'hC3, 16'd7, 1'b0, acc);
        chk_eq("div7_accept", 32'(acc), 32'd1);
        idle(90, 16'd7);

        // Reset during data bit 4, then an intact frame.
        step(1'b1, 8'h96, 16'd3, 1'b0, acc);
        idle(21, 16'd3);
        step(1'b0, 8'h00, 16'd3, 1'b1, acc);
        step(1'b0, 8'h00, 16'd3, 1'b0, acc);
        step(1'b1, 8'h5A, 16'd2, 1'b0, acc);
        chk_eq("post_rst_accept", 32'(acc), 32'd1);
        idle(40, 16'd2);

        // 0x55 at period 2 on both builds (7-bit build sends two stop bits).
        step(1'b1, 8'h55, 16'd1, 1'b0, acc);
        idle(25, 16'd1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 2) != 0), 8'($urandom), 16'($urandom_range(0, 4)),
                 ($urandom_range(0, 99) == 0), acc);
        end
        idle(80, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
